// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module  : alu_div
// Brief   : Iterative restoring divider, one quotient bit per clock, with a
//           9-bit request key returned alongside the result. Define
//           ALU_DIV_SIGNED_EN for two's-complement operands (adds a FIX cycle).
// Revision: 1.0  initial release
// ============================================================================
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [8:0]       key_in,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div0,
  output logic [8:0]       key_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [8:0]       key_q, key_d;
  logic [8:0]       key_out_q, key_out_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef ALU_DIV_SIGNED_EN
  logic neg_q, neg_d;
  logic sgn_a_q, sgn_a_d;

  // Magnitude of the most-negative value is correct when read as unsigned.
  assign mag_a = inA[WIDTH-1] ? -inA : inA;
  assign mag_b = inB[WIDTH-1] ? -inB : inB;
`else
  assign mag_a = inA;
  assign mag_b = inB;
`endif

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial sign.
  assign shift_w  = {prem_q, dvd_q[WIDTH-1]};
  assign diff_w   = shift_w - {1'b0, dvs_q};
  assign prem_nxt = diff_w[WIDTH] ? shift_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
  assign dvd_nxt  = {dvd_q[WIDTH-2:0], ~diff_w[WIDTH]};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_out_d = key_out_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    div0_d    = div0_q;
`ifdef ALU_DIV_SIGNED_EN
    neg_d     = neg_q;
    sgn_a_d   = sgn_a_q;
`endif
    if (clr) begin
      state_d   = IDLE;
      ready_d   = 1'b1;
      cnt_d     = '0;
      quot_d    = '0;
      rem_d     = '0;
      div0_d    = 1'b0;
      key_out_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          ready_d = 1'b1;
          if (state_q == DONE) state_d = IDLE;
          if (en) begin
            dvd_d  = mag_a;
            dvs_d  = mag_b;
            prem_d = '0;
            key_d  = key_in;
            cnt_d  = CW'(WIDTH-1);
`ifdef ALU_DIV_SIGNED_EN
            neg_d   = inA[WIDTH-1] ^ inB[WIDTH-1];
            sgn_a_d = inA[WIDTH-1];
`endif
            if (inB == '0) begin
              state_d   = DONE;
              valid_d   = 1'b1;
              quot_d    = '1;
              rem_d     = inA;
              div0_d    = 1'b1;
              key_out_d = key_in;
            end else begin
              state_d = BUSY;
              ready_d = 1'b0;
            end
          end
        end
        BUSY: begin
          dvd_d  = dvd_nxt;
          prem_d = prem_nxt;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            cnt_d = '0;
`ifdef ALU_DIV_SIGNED_EN
            state_d = FIX;
`else
            state_d   = DONE;
            ready_d   = 1'b1;
            valid_d   = 1'b1;
            quot_d    = dvd_nxt;
            rem_d     = prem_nxt;
            div0_d    = 1'b0;
            key_out_d = key_q;
`endif
          end
        end
`ifdef ALU_DIV_SIGNED_EN
        FIX: begin
          state_d   = DONE;
          ready_d   = 1'b1;
          valid_d   = 1'b1;
          quot_d    = neg_q ? -dvd_q : dvd_q;
          rem_d     = sgn_a_q ? -prem_q : prem_q;
          div0_d    = 1'b0;
          key_out_d = key_q;
        end
`endif
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      key_out_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      div0_q    <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      sgn_a_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      key_out_q <= key_out_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      div0_q    <= div0_d;
`ifdef ALU_DIV_SIGNED_EN
      neg_q     <= neg_d;
      sgn_a_q   <= sgn_a_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign quot    = quot_q;
  assign rem     = rem_q;
  assign div0    = div0_q;
  assign key_out = key_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_div
// Brief   : Directed-vector bench for alu_div (WIDTH=32), expected values
//           computed by hand; honours ALU_DIV_SIGNED_EN.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_div;

`ifdef ALU_DIV_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk;
  logic        rst;
  logic        clr;
  logic        en;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [8:0]  key_in;
  logic        ready;
  logic        valid;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div0;
  logic [8:0]  key_out;

  int test_cnt = 0;
  int fail_cnt = 0;

  alu_div #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (en),
    .inA     (inA),
    .inB     (inB),
    .key_in  (key_in),
    .ready   (ready),
    .valid   (valid),
    .quot    (quot),
    .rem     (rem),
    .div0    (div0),
    .key_out (key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for valid; returns in the valid cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [8:0] k, input int exp_lat, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_d0);
    int n;
    @(negedge clk);
    inA = a; inB = b; key_in = k; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    check_eq({tag, "_rdy"}, {31'd0, ready}, {31'd0, exp_lat == 0});
    n = 0;
    while (!valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_q"}, quot, exp_q);
    check_eq({tag, "_r"}, rem, exp_r);
    check_eq({tag, "_d0"}, {31'd0, div0}, {31'd0, exp_d0});
    check_eq({tag, "_key"}, {23'd0, key_out}, {23'd0, k});
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b0; clr = 1'b0; en = 1'b0;
    inA = '0; inB = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_quot", quot, 32'd0);
    check_eq("rst_rem", rem, 32'd0);
    check_eq("rst_div0", {31'd0, div0}, 32'd0);
    check_eq("rst_key", {23'd0, key_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("d1764", 32'd1764, 32'd42, 9'h1A5, LAT, 32'd42, 32'd0, 1'b0);
    @(posedge clk); #1;
    check_eq("d1764_pulse", {31'd0, valid}, 32'd0);
    check_eq("d1764_hold", quot, 32'd42);
    check_eq("d1764_holdkey", {23'd0, key_out}, 32'h1A5);

`ifdef ALU_DIV_SIGNED_EN
    run_op("sneg", 32'hFFFFF91C, 32'd42, 9'h011, LAT, 32'hFFFFFFD6, 32'd0, 1'b0);
    run_op("sm7", 32'hFFFFFFF9, 32'd2, 9'h012, LAT, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("smin", 32'h80000000, 32'hFFFFFFFF, 9'h013, LAT, 32'h80000000, 32'd0, 1'b0);
    run_op("sdiv0", 32'hFFFFFF85, 32'd0, 9'h014, 0, 32'hFFFFFFFF, 32'hFFFFFF85, 1'b1);
`else
    run_op("ffff7", 32'hFFFFFFFF, 32'd7, 9'h004, LAT, 32'h24924924, 32'd3, 1'b0);
    run_op("d5by9", 32'd5, 32'd9, 9'h005, LAT, 32'd0, 32'd5, 1'b0);
    run_op("msb", 32'h80000000, 32'hFFFFFFFF, 9'h006, LAT, 32'd0, 32'h80000000, 1'b0);
`endif
    run_op("d1000", 32'd1000, 32'd7, 9'h007, LAT, 32'd142, 32'd6, 1'b0);
    run_op("dz", 32'd123, 32'd0, 9'h003, 0, 32'hFFFFFFFF, 32'd123, 1'b1);
    @(posedge clk); #1;
    check_eq("dz_pulse", {31'd0, valid}, 32'd0);

    // Back-to-back: second request held through the first's valid cycle
    run_op("b2b1", 32'd1764, 32'd42, 9'h001, LAT, 32'd42, 32'd0, 1'b0);
    inA = 32'd100; inB = 32'd10; key_in = 9'h002; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    n = 1;
    while (!valid && n < 100) begin
      if (n == 10) begin
        inA = 32'd7; inB = 32'd1; key_in = 9'h0FF; en = 1'b1;
      end else begin
        en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    en = 1'b0;
    check_eq("b2b_gap", n, LAT + 1);
    check_eq("b2b_q", quot, 32'd10);
    check_eq("b2b_key", {23'd0, key_out}, 32'h002);
    count_valid(40, pulses);
    check_eq("busy_en_ignored", pulses, 0);

    // Synchronous abort at cycle 10
    @(negedge clk);
    inA = 32'd1764; inB = 32'd42; key_in = 9'h0AA; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("clr_ready", {31'd0, ready}, 32'd1);
    check_eq("clr_quot", quot, 32'd0);
    check_eq("clr_key", {23'd0, key_out}, 32'd0);
    count_valid(40, pulses);
    check_eq("clr_no_valid", pulses, 0);

    // clr and en together: nothing accepted
    @(negedge clk);
    inA = 32'd50; inB = 32'd5; key_in = 9'h055; en = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b0;
    check_eq("clren_ready", {31'd0, ready}, 32'd1);
    count_valid(40, pulses);
    check_eq("clren_no_valid", pulses, 0);

    // Async reset mid-BUSY
    run_op("pre_rst", 32'd90, 32'd9, 9'h009, LAT, 32'd10, 32'd0, 1'b0);
    @(negedge clk);
    inA = 32'd1764; inB = 32'd42; key_in = 9'h0BB; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_ready", {31'd0, ready}, 32'd1);
    check_eq("arst_quot", quot, 32'd0);
    check_eq("arst_key", {23'd0, key_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    count_valid(40, pulses);
    check_eq("arst_no_valid", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_div.md
# alu_div

Iterative restoring divider for the ALU datapath, the inverse of the SB_MAC16 multiply path. Accepts a dividend/divisor pair tagged with a 9-bit key, produces quotient and remainder one bit per clock, and returns the key with the result so the issuing sequencer can match responses. Sits beside the multiplier and shares its operand buses (`inA`, `inB`) and its key convention (`key_in`/`key_out`).

## Interface
- `WIDTH`, 32: operand, quotient and remainder width in bits; legal range 4..32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `clr`  in  1  synchronous abort, active-high; overrides `en`.
- `en`  in  1  start strobe; sampled only when `ready`=1.
- `inA`  in  WIDTH  dividend.
- `inB`  in  WIDTH  divisor.
- `key_in`  in  9  request tag; latched with the operands.
- `ready`  out  1  high in IDLE and DONE; the block can accept `en`.
- `valid`  out  1  one-cycle pulse; result outputs are valid.
- `quot`  out  WIDTH  quotient.
- `rem`  out  WIDTH  remainder.
- `div0`  out  1  divisor was zero; qualified by `valid`.
- `key_out`  out  9  tag of the request that produced the current result.

## Operation
- States: IDLE, BUSY, FIX (only with the macro), DONE.
- Reset (`rst`=0): state IDLE, `ready`=1, `valid`=0, `div0`=0, `quot`=0, `rem`=0, `key_out`=0, iteration counter=0.
- Accept: on an edge with `ready`=1 and `en`=1, latch `inA`, `inB` and `key_in`, clear the partial remainder, and load counter=WIDTH-1. The next state is BUSY, or DONE directly if `inB`=0.
- BUSY, each edge: partial remainder shifts left by 1 and takes the next dividend MSB. Trial subtract is WIDTH+1 bits wide. A non-negative result is kept and the quotient bit is 1; a negative result is discarded and the quotient bit is 0. The counter decrements, and when it reaches 0 the state moves to DONE (or FIX).
- DONE: `valid`=1 for exactly one cycle. `quot`, `rem`, `div0` and `key_out` hold their values until the next result or `clr`. The next state is IDLE, or a new accept if `en`=1.
- Divide by zero: `quot`=all ones, `rem`=`inA`, `div0`=1; no iterations run.
- `en` while in BUSY or FIX: ignored and not queued. The requester must wait for `ready`.
- `clr`=1 in any state: next state IDLE, `valid`=0, result outputs and `key_out` cleared to 0. A pending result is dropped with no `valid` pulse. `clr` and `en` asserted together: `clr` wins and nothing is accepted.
- Reset mid-operation: immediate return to the reset values, no `valid`.

## Timing
- Accept edge = E0. Normal division: `valid` high in the cycle after edge E_WIDTH (E32 at the default width).
- Divide by zero: `valid` high in the cycle after E0.
- Signed build: add 1 cycle for FIX.
- Back-to-back operation: `en` in the DONE cycle is accepted at that edge, giving a throughput of one result per WIDTH+1 cycles.
- `ready` is low from the cycle after the accept through the last BUSY/FIX cycle.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `ALU_DIV_SIGNED_EN` defined:
  - Operands are two's complement and magnitudes are divided.
  - FIX state: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: `quot`=-1, `rem`=`inA`.
  - Most-negative dividend ÷ -1: `quot`=most-negative value (wraps), `rem`=0, `div0`=0.
- Undefined: unsigned only, no FIX state, latency WIDTH.

## Test plan
- Reset, then `inA`=1764, `inB`=42, `key_in`=0x1A5, `en` for 1 cycle -> after 32 edges `valid`=1 for 1 cycle, `quot`=42, `rem`=0, `key_out`=0x1A5, `div0`=0.
- `inA`=0xFFFFFFFF, `inB`=7 -> `quot`=0x24924924, `rem`=3. Then `inA`=5, `inB`=9 -> `quot`=0, `rem`=5.
- `inB`=0, `inA`=123, `key_in`=0x003 -> `valid` in the cycle after accept, `div0`=1, `quot`=0xFFFFFFFF, `rem`=123.
- Back-to-back: second `en` (`inA`=100, `inB`=10, key 0x002) held during the DONE cycle of the first -> accepted. The second `valid` comes 33 cycles after the first, with `quot`=10 and key 0x002. An `en` pulse during BUSY produces no extra result.
- Abort: `clr` at cycle 10 of a division -> `ready`=1 next cycle, no `valid`, outputs 0. An async `rst` pulse mid-BUSY gives the same result.
- Signed build: -1764 ÷ 42 -> `quot`=-42, `rem`=0; -7 ÷ 2 -> `quot`=-3, `rem`=-1. Latency 33 cycles.
